// File: rtl/mul_requester_pkg.sv
// rtl/mul_requester_pkg.sv - command field layout and sizing helpers for mul_requester
package mul_requester_pkg;

   localparam int DEFAULT_WIDTH = 4;

   // cmd_msg layout is {acc, b, a} with a in the low bits
   function automatic int acc_bit(input int w);
      return 2 * w;
   endfunction

   function automatic int a_msb(input int w);
      return w - 1;
   endfunction

   function automatic int b_lsb(input int w);
      return w;
   endfunction

   function automatic int b_msb(input int w);
      return 2 * w - 1;
   endfunction

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   typedef struct packed {
      logic                     acc;
      logic [DEFAULT_WIDTH-1:0] b;
      logic [DEFAULT_WIDTH-1:0] a;
   } mul_cmd_t;

endpackage

// File: rtl/mul_requester_flagq.sv
// rtl/mul_requester_flagq.sv - 1-bit accumulate-flag FIFO; its occupancy is the outstanding count
module mul_requester_flagq
   import mul_requester_pkg::*;
#(
   parameter int p_depth = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
   localparam int CNT_W = cnt_width(p_depth);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(p_depth - 1);

   logic [p_depth-1:0] mem;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == CNT_W'(p_depth));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // pointers wrap at p_depth, which need not be a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/mul_requester.sv
// rtl/mul_requester.sv - issues multiply requests, tracks outstanding, accumulates in-order results
// Optional watchdog compiled in with MUL_REQUESTER_TIMEOUT_EN.
module mul_requester
   import mul_requester_pkg::*;
#(
   parameter int p_width   = 4,
   parameter int p_max_out = 2,
   parameter int p_timeout = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_val,
   output logic                 cmd_rdy,
   input  logic [2*p_width:0]   cmd_msg,
   output logic                 mul_req_val,
   input  logic                 mul_req_rdy,
   output logic [2*p_width-1:0] mul_req_msg,
   input  logic                 mul_resp_val,
   output logic                 mul_resp_rdy,
   input  logic [2*p_width-1:0] mul_resp_msg,
   output logic                 out_val,
   input  logic                 out_rdy,
   output logic [2*p_width-1:0] out_msg,
   output logic                 err
);

   localparam int ACC_BIT = acc_bit(p_width);
   localparam int MSG_MSB = b_msb(p_width);

   logic [2*p_width-1:0] accum;
   logic [2*p_width-1:0] sum;
   logic                 flag_full;
   logic                 flag_empty;
   logic                 head_acc;
   logic                 can_issue;
   logic                 issue;
   logic                 accept;

   // flag queue full/empty are exactly outstanding==p_max_out / outstanding==0
   assign can_issue    = ~flag_full & ~err;
   assign mul_req_msg  = cmd_msg[MSG_MSB:0];
   assign mul_req_val  = cmd_val & can_issue;
   assign cmd_rdy      = mul_req_rdy & can_issue;
   assign issue        = cmd_val & cmd_rdy;
   assign mul_resp_rdy = (~out_val | out_rdy) & ~flag_empty;
   assign accept       = mul_resp_val & mul_resp_rdy;
   assign sum          = head_acc ? accum + mul_resp_msg : mul_resp_msg;

   mul_requester_flagq #(
      .p_depth(p_max_out)
   ) u_flagq (
      .clk  (clk),
      .reset(reset),
      .push (issue),
      .din  (cmd_msg[ACC_BIT]),
      .pop  (accept),
      .dout (head_acc),
      .full (flag_full),
      .empty(flag_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         accum   <= '0;
         out_msg <= '0;
         out_val <= 1'b0;
      end else if (accept) begin
         accum   <= sum;
         out_msg <= sum;
         out_val <= 1'b1;
      end else if (out_rdy) begin
         out_val <= 1'b0;
      end
   end

`ifdef MUL_REQUESTER_TIMEOUT_EN
   localparam int WD_W = cnt_width(p_timeout);

   logic [WD_W-1:0] wd_cnt;

   // err latches on the stalled cycle that brings the count to p_timeout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt <= '0;
         err    <= 1'b0;
      end else if (flag_empty || accept) begin
         wd_cnt <= '0;
      end else begin
         if (wd_cnt != WD_W'(p_timeout)) wd_cnt <= wd_cnt + 1'b1;
         if (wd_cnt == WD_W'(p_timeout - 1)) err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_requester.sv
// tb/tb_mul_requester.sv - scoreboard bench for mul_requester with a behavioural multiplier
module tb_mul_requester;
   import mul_requester_pkg::*;

   localparam int W  = 4;
   localparam int MO = 2;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic           cmd_val;
   logic           cmd_rdy;
   logic [2*W:0]   cmd_msg;
   logic           mul_req_val;
   logic           mul_req_rdy;
   logic [2*W-1:0] mul_req_msg;
   logic           mul_resp_val = 1'b0;
   logic           mul_resp_rdy;
   logic [2*W-1:0] mul_resp_msg = '0;
   logic           out_val;
   logic           out_rdy;
   logic [2*W-1:0] out_msg;
   logic           err;

   int             checks = 0;
   int             failures = 0;
   int             cycle = 0;
   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] req_q[$];
   logic [2*W-1:0] exp_v;
   logic [2*W-1:0] m_acc;
   logic           resp_en;

   mul_requester #(
      .p_width  (W),
      .p_max_out(MO),
      .p_timeout(TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_val     (cmd_val),
      .cmd_rdy     (cmd_rdy),
      .cmd_msg     (cmd_msg),
      .mul_req_val (mul_req_val),
      .mul_req_rdy (mul_req_rdy),
      .mul_req_msg (mul_req_msg),
      .mul_resp_val(mul_resp_val),
      .mul_resp_rdy(mul_resp_rdy),
      .mul_resp_msg(mul_resp_msg),
      .out_val     (out_val),
      .out_rdy     (out_rdy),
      .out_msg     (out_msg),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   // in-order multiplier: records requests at the edge, presents the head product 1 ns later
   always @(posedge clk) begin
      if (reset) begin
         req_q.delete();
      end else begin
         if (mul_resp_val && mul_resp_rdy) void'(req_q.pop_front());
         if (mul_req_val && mul_req_rdy)
            req_q.push_back({{W{1'b0}}, mul_req_msg[W-1:0]} * {{W{1'b0}}, mul_req_msg[2*W-1:W]});
      end
      #1;
      mul_resp_val = resp_en && (req_q.size() > 0);
      mul_resp_msg = (req_q.size() > 0) ? req_q[0] : '0;
   end

   always @(negedge clk) begin
      if (!reset && out_val && out_rdy) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_extra: out_msg=%0d delivered, expected no result", out_msg);
         end else begin
            exp_v = exp_q.pop_front();
            if (out_msg !== exp_v) begin
               failures++;
               $display("FAIL scoreboard_value: out_msg=%0d, expected %0d", out_msg, exp_v);
            end
         end
      end
   end

   task automatic send_cmd(input logic acc, input logic [W-1:0] b, input logic [W-1:0] a);
      mul_cmd_t       c;
      logic           fired;
      logic [2*W-1:0] prod;
      c.acc   = acc;
      c.b     = b;
      c.a     = a;
      cmd_msg = c;
      cmd_val = 1'b1;
      fired   = 1'b0;
      for (int i = 0; i < 40 && !fired; i++) begin
         @(negedge clk);
         if (cmd_rdy) begin
            fired = 1'b1;
            @(posedge clk);
            #1;
         end
      end
      cmd_val = 1'b0;
      if (!fired) begin
         checks++;
         failures++;
         $display("FAIL cmd_issue_timeout: cmd_rdy=%0b, expected 1 within 40 cycles", cmd_rdy);
      end else begin
         prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
         m_acc = acc ? m_acc + prod : prod;
         exp_q.push_back(m_acc);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && req_q.size() == 0) break;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (mul_resp_val && mul_resp_rdy) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_accept_timeout: mul_resp_rdy=%0b, expected an accept within 40 cycles", name, mul_resp_rdy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      cmd_val     = 1'b0;
      cmd_msg     = '0;
      mul_req_rdy = 1'b1;
      out_rdy     = 1'b1;
      resp_en     = 1'b1;
      m_acc       = '0;
      repeat (2) @(posedge clk);
      #1;
      checks += 5;
      if (out_val !== 1'b0) begin failures++; $display("FAIL reset_out_val: got %0b, expected 0", out_val); end
      if (out_msg !== '0) begin failures++; $display("FAIL reset_out_msg: got %0d, expected 0", out_msg); end
      if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b, expected 0", err); end
      if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL reset_cmd_rdy: got %0b, expected 1", cmd_rdy); end
      if (mul_resp_rdy !== 1'b0) begin failures++; $display("FAIL reset_resp_rdy: got %0b, expected 0", mul_resp_rdy); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      out_rdy = 1'b1;
      resp_en = 1'b1;
      send_cmd(1'b0, 4'd3, 4'd5);
      wait_accept("single");
      checks += 2;
      if (out_val !== 1'b1) begin failures++; $display("FAIL single_out_val: got %0b, expected 1", out_val); end
      if (out_msg !== 8'd15) begin failures++; $display("FAIL single_out_msg: got %0d, expected 15", out_msg); end
      wait_drain();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL single_drain: %0d results missing, expected 0", exp_q.size()); end
   endtask

   task automatic test_accumulate();
      out_rdy = 1'b1;
      resp_en = 1'b1;
      send_cmd(1'b0, 4'd2, 4'd3);
      send_cmd(1'b1, 4'd4, 4'd4);
      send_cmd(1'b1, 4'd1, 4'd7);
      send_cmd(1'b1, 4'd15, 4'd15);
      send_cmd(1'b1, 4'd1, 4'd3);
      wait_drain();
      checks += 2;
      if (exp_q.size() != 0) begin failures++; $display("FAIL accum_drain: %0d results missing, expected 0", exp_q.size()); end
      if (out_msg !== 8'd1) begin failures++; $display("FAIL accum_wrap: got %0d, expected 1", out_msg); end
   endtask

   task automatic test_outstanding_limit();
      mul_cmd_t c;
      out_rdy = 1'b1;
      resp_en = 1'b0;
      @(posedge clk);
      #1;
      send_cmd(1'b0, 4'd2, 4'd2);
      send_cmd(1'b0, 4'd3, 4'd2);
      c.acc   = 1'b0;
      c.b     = 4'd1;
      c.a     = 4'd2;
      cmd_msg = c;
      cmd_val = 1'b1;
      repeat (3) @(negedge clk);
      checks += 2;
      if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL limit_cmd_rdy: got %0b, expected 0", cmd_rdy); end
      if (mul_req_val !== 1'b0) begin failures++; $display("FAIL limit_req_val: got %0b, expected 0", mul_req_val); end
      cmd_val = 1'b0;
      resp_en = 1'b1;
      wait_accept("limit");
      checks++;
      if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL limit_reopen: cmd_rdy=%0b, expected 1", cmd_rdy); end
      wait_drain();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL limit_drain: %0d results missing, expected 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      logic [2*W-1:0] held;
      out_rdy = 1'b0;
      resp_en = 1'b1;
      send_cmd(1'b0, 4'd2, 4'd5);
      send_cmd(1'b0, 4'd3, 4'd3);
      @(negedge clk);
      held = out_msg;
      checks += 3;
      if (out_val !== 1'b1) begin failures++; $display("FAIL bp_out_val: got %0b, expected 1", out_val); end
      if (mul_resp_rdy !== 1'b0) begin failures++; $display("FAIL bp_resp_rdy: got %0b, expected 0", mul_resp_rdy); end
      if (out_msg !== exp_q[0]) begin failures++; $display("FAIL bp_first: got %0d, expected %0d", out_msg, exp_q[0]); end
      repeat (3) @(negedge clk);
      checks += 2;
      if (out_msg !== held) begin failures++; $display("FAIL bp_stable: got %0d, expected %0d", out_msg, held); end
      if (mul_resp_rdy !== 1'b0) begin failures++; $display("FAIL bp_hold_rdy: got %0b, expected 0", mul_resp_rdy); end
      @(posedge clk);
      #1;
      out_rdy = 1'b1;
      @(posedge clk);
      #1;
      checks += 2;
      if (out_val !== 1'b1) begin failures++; $display("FAIL bp_release_val: got %0b, expected 1", out_val); end
      if (out_msg !== 8'd9) begin failures++; $display("FAIL bp_release_msg: got %0d, expected 9", out_msg); end
      wait_drain();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain: %0d results missing, expected 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int t0;
      int elapsed;
      out_rdy = 1'b1;
      resp_en = 1'b1;
      t0 = cycle;
      for (int i = 0; i < 8; i++)
         send_cmd(1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)));
      wait_drain();
      elapsed = cycle - t0;
      checks += 2;
      if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain: %0d results missing, expected 0", exp_q.size()); end
      if (elapsed > 13) begin failures++; $display("FAIL b2b_throughput: took %0d cycles, expected at most 13", elapsed); end
   endtask

   task automatic test_reset_mid();
      out_rdy = 1'b0;
      resp_en = 1'b0;
      send_cmd(1'b0, 4'd2, 4'd3);
      send_cmd(1'b1, 4'd2, 4'd4);
      resp_en = 1'b1;
      wait_accept("rmid");
      send_cmd(1'b0, 4'd5, 4'd5);
      reset = 1'b1;
      #1;
      checks += 5;
      if (out_val !== 1'b0) begin failures++; $display("FAIL rmid_out_val: got %0b, expected 0", out_val); end
      if (out_msg !== '0) begin failures++; $display("FAIL rmid_out_msg: got %0d, expected 0", out_msg); end
      if (err !== 1'b0) begin failures++; $display("FAIL rmid_err: got %0b, expected 0", err); end
      if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL rmid_cmd_rdy: got %0b, expected 1", cmd_rdy); end
      if (mul_resp_rdy !== 1'b0) begin failures++; $display("FAIL rmid_resp_rdy: got %0b, expected 0", mul_resp_rdy); end
      exp_q.delete();
      m_acc = '0;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      out_rdy = 1'b1;
      send_cmd(1'b1, 4'd3, 4'd5);
      send_cmd(1'b0, 4'd2, 4'd6);
      wait_drain();
      checks += 2;
      if (exp_q.size() != 0) begin failures++; $display("FAIL rmid_drain: %0d results missing, expected 0", exp_q.size()); end
      if (out_msg !== 8'd12) begin failures++; $display("FAIL rmid_after: got %0d, expected 12", out_msg); end
   endtask

`ifdef MUL_REQUESTER_TIMEOUT_EN
   task automatic test_watchdog();
      out_rdy = 1'b1;
      resp_en = 1'b0;
      @(posedge clk);
      #1;
      send_cmd(1'b0, 4'd3, 4'd4);
      repeat (TO - 1) @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL wd_early: err=%0b, expected 0", err); end
      @(posedge clk);
      #1;
      cmd_val = 1'b1;
      #1;
      checks += 3;
      if (err !== 1'b1) begin failures++; $display("FAIL wd_fire: err=%0b, expected 1", err); end
      if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL wd_cmd_rdy: got %0b, expected 0", cmd_rdy); end
      if (mul_req_val !== 1'b0) begin failures++; $display("FAIL wd_req_val: got %0b, expected 0", mul_req_val); end
      cmd_val = 1'b0;
      resp_en = 1'b1;
      wait_drain();
      checks += 2;
      if (exp_q.size() != 0) begin failures++; $display("FAIL wd_drain: %0d results missing, expected 0", exp_q.size()); end
      if (err !== 1'b1) begin failures++; $display("FAIL wd_sticky: err=%0b, expected 1", err); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_accumulate();
      test_outstanding_limit();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef MUL_REQUESTER_TIMEOUT_EN
      test_watchdog();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at 200000 ns, expected completion");
      $fatal(1);
   end

endmodule
